// File: rtl/armored40_link.sv
// armored40_link: single-lane armored40 link core.
// TX scrambles the payload and SECDED-encodes it into a 40-bit line word. RX bit-aligns
// the incoming stream, corrects/flags errors, descrambles and tracks word lock.
module armored40_link #(
    parameter logic [32:0] SCRAM_INIT = 33'h12345678,
    parameter int unsigned LOCK_CNT   = 64,
    parameter int unsigned UNLOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [32:0] din,
    output logic [39:0] tx_word,
    input  logic [39:0] rx_word,
    input  logic        sloop,
    output logic [32:0] dout,
    output logic        dout_fix,
    output logic        dout_fail,
    output logic        rx_wordlock,
    output logic [5:0]  rx_offset
);
    localparam logic [7:0] LockLast   = 8'(LOCK_CNT - 1);
    localparam logic [3:0] UnlockLast = 4'(UNLOCK_CNT - 1);

    typedef enum logic {StHunt, StLocked} state_e;

    // Scrambler feedback: two rotations of the previous state XORed together.
    function automatic logic [32:0] scram_f(input logic [32:0] x);
        return {x[25:0], x[32:26]} ^ {x[13:0], x[32:14]};
    endfunction

    // Data bits fill the non-power-of-two Hamming positions 3..39 in ascending order.
    function automatic logic [39:0] secded_enc(input logic [32:0] s);
        logic [39:0] w;
        logic [5:0]  chk;
        w = {s[32:26], 1'b0, s[25:11], 1'b0, s[10:4], 1'b0, s[3:1], 1'b0, s[0], 3'b000};
        chk = '0;
        for (int k = 0; k < 6; k++) begin
            for (int i = 1; i < 40; i++) begin
                if (i[k]) chk[k] = chk[k] ^ w[i];
            end
        end
        w[1]  = chk[0];
        w[2]  = chk[1];
        w[4]  = chk[2];
        w[8]  = chk[3];
        w[16] = chk[4];
        w[32] = chk[5];
        w[0]  = ^w[39:1];
        return w;
    endfunction

    logic [32:0] s_q, s_d;
    logic [39:0] tx_word_q, tx_word_d;
    logic [39:0] r1_q, r1_d, r2_q, r2_d;
    logic [79:0] rx_cat;
    logic [39:0] aligned, corrected;
    logic [5:0]  syn;
    logic        par, fix, fail;
    logic [32:0] s_rx;
    logic [32:0] q_q, q_d;
    logic [32:0] dout_q, dout_d;
    logic        fix_q, fix_d, fail_q, fail_d;
    state_e      state_q, state_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic [3:0]  bad_cnt_q, bad_cnt_d;
    logic [5:0]  offset_q, offset_d;

    // TX: scramble the payload against the previous scrambled word, then encode.
    always_comb begin
        s_d       = din ^ scram_f(s_q);
        tx_word_d = secded_enc(s_d);
    end

    // RX: input select, two-word window, alignment, SECDED decode and descramble.
    always_comb begin
        r1_d    = sloop ? tx_word_q : rx_word;
        r2_d    = r1_q;
        // r2 holds the older word, so the window reads in transmission order.
        rx_cat  = {r1_q, r2_q};
        aligned = rx_cat[{1'b0, offset_q} +: 40];
        syn     = '0;
        for (int i = 1; i < 40; i++) begin
            if (aligned[i]) syn = syn ^ i[5:0];
        end
        par       = ^aligned;
        fix       = 1'b0;
        fail      = 1'b0;
        corrected = aligned;
        if (par) begin
            if (syn <= 6'd39) begin
                fix       = 1'b1;
                corrected = aligned ^ (40'd1 << syn);
            end else begin
                fail = 1'b1;
            end
        end else if (syn != 6'd0) begin
            fail = 1'b1;
        end
        s_rx   = {corrected[39:33], corrected[31:17], corrected[15:9], corrected[7:5],
                  corrected[3]};
        // History follows every word, even failed ones, so the path resynchronises.
        q_d    = s_rx;
        dout_d = s_rx ^ scram_f(q_q);
        fix_d  = fix;
        fail_d = fail;
    end

    // Lock FSM next state: count clean words in HUNT (slipping on failures), count
    // failures in LOCKED.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        offset_d   = offset_q;
        unique case (state_q)
            StHunt: begin
                if (fail) begin
                    good_cnt_d = '0;
                    offset_d   = (offset_q == 6'd39) ? 6'd0 : offset_q + 6'd1;
                end else if (good_cnt_q == LockLast) begin
                    state_d    = StLocked;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end else begin
                    good_cnt_d = good_cnt_q + 8'd1;
                end
            end
            StLocked: begin
                if (!fail) begin
                    bad_cnt_d = '0;
                end else if (bad_cnt_q == UnlockLast) begin
                    state_d    = StHunt;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end else begin
                    bad_cnt_d = bad_cnt_q + 4'd1;
                end
            end
        endcase
    end

    // State registers for both paths.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s_q        <= SCRAM_INIT;
            tx_word_q  <= '0;
            r1_q       <= '0;
            r2_q       <= '0;
            q_q        <= SCRAM_INIT;
            dout_q     <= '0;
            fix_q      <= 1'b0;
            fail_q     <= 1'b0;
            state_q    <= StHunt;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            offset_q   <= '0;
        end else begin
            s_q        <= s_d;
            tx_word_q  <= tx_word_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            q_q        <= q_d;
            dout_q     <= dout_d;
            fix_q      <= fix_d;
            fail_q     <= fail_d;
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            offset_q   <= offset_d;
        end
    end

    assign tx_word     = tx_word_q;
    assign dout        = dout_q;
    assign dout_fix    = fix_q;
    assign dout_fail   = fail_q;
    assign rx_wordlock = (state_q == StLocked);
    assign rx_offset   = offset_q;

endmodule

// File: tb/tb_armored40_link.sv
// Bench for armored40_link: random payloads, a bit-delay channel with error injection,
// and a delay-line reference for the recovered payload.
module tb_armored40_link;
    localparam int LockCnt   = 64;
    localparam int UnlockCnt = 4;
    localparam int LogLen    = 4096;

    logic        clk, arst, sloop;
    logic [32:0] din, dout;
    logic [39:0] tx_word, rx_word;
    logic        dout_fix, dout_fail, rx_wordlock;
    logic [5:0]  rx_offset;

    int          n_checks, n_pass, cyc, ch_delay;
    logic [39:0] prev_tx;
    logic [32:0] din_log [LogLen];
    bit          fix_log [LogLen];
    bit          bad_log [LogLen];

    armored40_link #(
        .SCRAM_INIT(33'h12345678),
        .LOCK_CNT  (LockCnt),
        .UNLOCK_CNT(UnlockCnt)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .din        (din),
        .tx_word    (tx_word),
        .rx_word    (rx_word),
        .sloop      (sloop),
        .dout       (dout),
        .dout_fix   (dout_fix),
        .dout_fail  (dout_fail),
        .rx_wordlock(rx_wordlock),
        .rx_offset  (rx_offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle from a negedge: random payload, channel word with error mask.
    // Payload at cycle k must reappear on dout at cycle k+4; a corrupted channel word
    // at cycle k shows its fix/fail flag at cycle k+3.
    task automatic drive(input logic [39:0] mask, input bit fix_exp, input bit bad_exp);
        logic [63:0] r;
        logic [79:0] cat;
        if (cyc >= LogLen - 1) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, LogLen - 1);
            $fatal(1);
        end
        r            = {$urandom(), $urandom()};
        din          = r[32:0];
        din_log[cyc] = r[32:0];
        fix_log[cyc] = fix_exp;
        bad_log[cyc] = bad_exp;
        cat          = {tx_word, prev_tx};
        rx_word      = cat[40 - ch_delay +: 40] ^ mask;
        prev_tx      = tx_word;
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        sloop = 1'b1;
        for (int i = 0; i < 3; i++) drive('0, 1'b0, 1'b0);
        n_checks++; if (tx_word !== 40'd0) $display("FAIL reset_tx_word got=%h want=0", tx_word); else n_pass++;
        n_checks++; if (dout !== 33'd0) $display("FAIL reset_dout got=%h want=0", dout); else n_pass++;
        n_checks++; if (dout_fix !== 1'b0) $display("FAIL reset_fix got=%b want=0", dout_fix); else n_pass++;
        n_checks++; if (dout_fail !== 1'b0) $display("FAIL reset_fail got=%b want=0", dout_fail); else n_pass++;
        n_checks++; if (rx_wordlock !== 1'b0) $display("FAIL reset_lock got=%b want=0", rx_wordlock); else n_pass++;
        n_checks++; if (rx_offset !== 6'd0) $display("FAIL reset_offset got=%0d want=0", rx_offset); else n_pass++;
    endtask

    task automatic test_lock_loopback();
        int lock_at;
        arst = 1'b0;
        sloop = 1'b1;
        ch_delay = 0;
        lock_at = -1;
        for (int i = 1; i <= LockCnt + 2; i++) begin
            drive('0, 1'b0, 1'b0);
            if (rx_wordlock === 1'b1) begin
                lock_at = i;
                break;
            end
        end
        n_checks++;
        if (lock_at < LockCnt) $display("FAIL loop_lock_time got=%0d want=%0d..%0d", lock_at, LockCnt, LockCnt + 2);
        else n_pass++;
        n_checks++; if (rx_offset !== 6'd0) $display("FAIL loop_offset got=%0d want=0", rx_offset); else n_pass++;
        for (int i = 0; i < 100; i++) begin
            n_checks++;
            if (dout !== din_log[cyc-4]) $display("FAIL loop_dout cyc=%0d got=%h want=%h", cyc, dout, din_log[cyc-4]);
            else n_pass++;
            n_checks++;
            if ({dout_fix, dout_fail} !== 2'b00) $display("FAIL loop_flags cyc=%0d got=%b want=00", cyc, {dout_fix, dout_fail});
            else n_pass++;
            n_checks++; if (rx_wordlock !== 1'b1) $display("FAIL loop_lock cyc=%0d got=%b want=1", cyc, rx_wordlock); else n_pass++;
            drive('0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_single_flip();
        logic [39:0] m;
        sloop = 1'b0;
        ch_delay = 0;
        for (int i = 0; i < 60; i++) begin
            n_checks++;
            if (dout !== din_log[cyc-4]) $display("FAIL single_dout cyc=%0d got=%h want=%h", cyc, dout, din_log[cyc-4]);
            else n_pass++;
            n_checks++;
            if (dout_fix !== fix_log[cyc-3]) $display("FAIL single_fix cyc=%0d got=%b want=%b", cyc, dout_fix, fix_log[cyc-3]);
            else n_pass++;
            n_checks++; if (dout_fail !== 1'b0) $display("FAIL single_fail cyc=%0d got=%b want=0", cyc, dout_fail); else n_pass++;
            n_checks++; if (rx_wordlock !== 1'b1) $display("FAIL single_lock cyc=%0d got=%b want=1", cyc, rx_wordlock); else n_pass++;
            m = '0;
            if (i % 12 == 2 && i < 50) m[(i == 2) ? 17 : $urandom_range(39, 0)] = 1'b1;
            drive(m, m != '0, 1'b0);
        end
    endtask

    task automatic test_double_flip();
        logic [39:0] m;
        int b1, b2;
        for (int i = 0; i < 60; i++) begin
            if (!(bad_log[cyc-3] || bad_log[cyc-4])) begin
                n_checks++;
                if (dout !== din_log[cyc-4]) $display("FAIL double_dout cyc=%0d got=%h want=%h", cyc, dout, din_log[cyc-4]);
                else n_pass++;
            end
            n_checks++;
            if (dout_fail !== bad_log[cyc-3]) $display("FAIL double_fail cyc=%0d got=%b want=%b", cyc, dout_fail, bad_log[cyc-3]);
            else n_pass++;
            n_checks++; if (dout_fix !== 1'b0) $display("FAIL double_fix cyc=%0d got=%b want=0", cyc, dout_fix); else n_pass++;
            n_checks++; if (rx_wordlock !== 1'b1) $display("FAIL double_lock cyc=%0d got=%b want=1", cyc, rx_wordlock); else n_pass++;
            m = '0;
            if (i % 12 == 2 && i < 50) begin
                b1 = (i == 2) ? 5 : int'($urandom_range(39, 0));
                b2 = (i == 2) ? 30 : (b1 + 1 + int'($urandom_range(38, 0))) % 40;
                m[b1] = 1'b1;
                m[b2] = 1'b1;
            end
            drive(m, 1'b0, m != '0);
        end
    endtask

    task automatic test_unlock();
        logic [39:0] m;
        int lock_at;
        // Three consecutive double errors: lock must hold.
        for (int i = 0; i < 23; i++) begin
            if (!(bad_log[cyc-3] || bad_log[cyc-4])) begin
                n_checks++;
                if (dout !== din_log[cyc-4]) $display("FAIL unlock3_dout cyc=%0d got=%h want=%h", cyc, dout, din_log[cyc-4]);
                else n_pass++;
            end
            n_checks++;
            if (dout_fail !== bad_log[cyc-3]) $display("FAIL unlock3_fail cyc=%0d got=%b want=%b", cyc, dout_fail, bad_log[cyc-3]);
            else n_pass++;
            n_checks++; if (rx_wordlock !== 1'b1) $display("FAIL unlock3_lock cyc=%0d got=%b want=1", cyc, rx_wordlock); else n_pass++;
            m = '0;
            if (i < 3) m = 40'h1 << $urandom_range(19, 0) | 40'h1 << (20 + $urandom_range(19, 0));
            drive(m, 1'b0, m != '0);
        end
        // Four consecutive double errors: lock must drop, offset kept at 0.
        for (int i = 0; i < 12; i++) begin
            if (!(bad_log[cyc-3] || bad_log[cyc-4])) begin
                n_checks++;
                if (dout !== din_log[cyc-4]) $display("FAIL unlock4_dout cyc=%0d got=%h want=%h", cyc, dout, din_log[cyc-4]);
                else n_pass++;
            end
            n_checks++;
            if (dout_fail !== bad_log[cyc-3]) $display("FAIL unlock4_fail cyc=%0d got=%b want=%b", cyc, dout_fail, bad_log[cyc-3]);
            else n_pass++;
            if (i <= 5) begin
                n_checks++; if (rx_wordlock !== 1'b1) $display("FAIL unlock4_held cyc=%0d got=%b want=1", cyc, rx_wordlock); else n_pass++;
            end
            if (i >= 7) begin
                n_checks++; if (rx_wordlock !== 1'b0) $display("FAIL unlock4_drop cyc=%0d got=%b want=0", cyc, rx_wordlock); else n_pass++;
                n_checks++; if (rx_offset !== 6'd0) $display("FAIL unlock4_offset cyc=%0d got=%0d want=0", cyc, rx_offset); else n_pass++;
            end
            m = '0;
            if (i < 4) m = 40'h1 << $urandom_range(19, 0) | 40'h1 << (20 + $urandom_range(19, 0));
            drive(m, 1'b0, m != '0);
        end
        lock_at = -1;
        for (int i = 0; i < LockCnt + 4; i++) begin
            drive('0, 1'b0, 1'b0);
            if (rx_wordlock === 1'b1) begin
                lock_at = i;
                break;
            end
        end
        n_checks++; if (lock_at < 0) $display("FAIL relock got=none want=lock within %0d", LockCnt + 4); else n_pass++;
        n_checks++; if (rx_offset !== 6'd0) $display("FAIL relock_offset got=%0d want=0", rx_offset); else n_pass++;
    endtask

    task automatic test_delay17();
        int seen;
        ch_delay = 17;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            drive('0, 1'b0, 1'b0);
            if (rx_wordlock === 1'b0) begin
                seen = 1;
                break;
            end
        end
        n_checks++; if (seen != 1) $display("FAIL delay_unlock got=held want=drop"); else n_pass++;
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            drive('0, 1'b0, 1'b0);
            if (rx_wordlock === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_checks++; if (seen != 1) $display("FAIL delay_lock got=none want=lock"); else n_pass++;
        n_checks++; if (rx_offset !== 6'd17) $display("FAIL delay_offset got=%0d want=17", rx_offset); else n_pass++;
        for (int i = 0; i < 100; i++) begin
            n_checks++;
            if (dout !== din_log[cyc-4]) $display("FAIL delay_dout cyc=%0d got=%h want=%h", cyc, dout, din_log[cyc-4]);
            else n_pass++;
            n_checks++;
            if ({dout_fix, dout_fail} !== 2'b00) $display("FAIL delay_flags cyc=%0d got=%b want=00", cyc, {dout_fix, dout_fail});
            else n_pass++;
            n_checks++; if (rx_wordlock !== 1'b1) $display("FAIL delay_lock_hold cyc=%0d got=%b want=1", cyc, rx_wordlock); else n_pass++;
            drive('0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int lock_at;
        #2 arst = 1'b1;
        #1;
        n_checks++; if (tx_word !== 40'd0) $display("FAIL mid_tx_word got=%h want=0", tx_word); else n_pass++;
        n_checks++; if (dout !== 33'd0) $display("FAIL mid_dout got=%h want=0", dout); else n_pass++;
        n_checks++; if ({dout_fix, dout_fail} !== 2'b00) $display("FAIL mid_flags got=%b want=00", {dout_fix, dout_fail}); else n_pass++;
        n_checks++; if (rx_wordlock !== 1'b0) $display("FAIL mid_lock got=%b want=0", rx_wordlock); else n_pass++;
        n_checks++; if (rx_offset !== 6'd0) $display("FAIL mid_offset got=%0d want=0", rx_offset); else n_pass++;
        drive('0, 1'b0, 1'b0);
        arst = 1'b0;
        sloop = 1'b1;
        ch_delay = 0;
        lock_at = -1;
        for (int i = 1; i <= LockCnt + 2; i++) begin
            drive('0, 1'b0, 1'b0);
            if (rx_wordlock === 1'b1) begin
                lock_at = i;
                break;
            end
        end
        n_checks++;
        if (lock_at < LockCnt) $display("FAIL mid_relock_time got=%0d want=%0d..%0d", lock_at, LockCnt, LockCnt + 2);
        else n_pass++;
        for (int i = 0; i < 50; i++) begin
            n_checks++;
            if (dout !== din_log[cyc-4]) $display("FAIL mid_dout_seq cyc=%0d got=%h want=%h", cyc, dout, din_log[cyc-4]);
            else n_pass++;
            n_checks++;
            if ({dout_fix, dout_fail} !== 2'b00) $display("FAIL mid_flags_seq cyc=%0d got=%b want=00", cyc, {dout_fix, dout_fail});
            else n_pass++;
            drive('0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        ch_delay = 0;
        prev_tx  = '0;
        arst     = 1'b1;
        sloop    = 1'b1;
        din      = '0;
        rx_word  = '0;
        for (int i = 0; i < LogLen; i++) begin
            din_log[i] = '0;
            fix_log[i] = 1'b0;
            bad_log[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_lock_loopback();
        test_single_flip();
        test_double_flip();
        test_unlock();
        test_delay17();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/armored40_link.md
Name: armored40_link

Overview:
- Single-lane digital core of the armored40 serial link.
- TX path: scrambles a 33-bit payload each cycle, then SECDED-encodes it into a 40-bit line word (33 data + 6 Hamming + 1 overall parity).
- RX path: bit-aligns the incoming 40-bit stream, corrects single-bit errors, flags uncorrectable ones, descrambles, and reports word lock.
- Sits between user logic and the transceiver PCS. An internal serial loopback (sloop) ties TX to RX.

Parameters:
- SCRAM_INIT, 33'h12345678, reset value of the TX scrambler state and the RX descrambler state.
- LOCK_CNT, 64, consecutive clean aligned words needed to declare lock (range 2..255).
- UNLOCK_CNT, 4, consecutive failed words that drop lock (range 1..15).

Ports:
- clk  in  1  sole clock; TX and RX share it.
- arst  in  1  asynchronous, active-high reset.
- din  in  33  TX payload, accepted every cycle.
- tx_word  out  40  encoded line word; bit 0 is transmitted first.
- rx_word  in  40  received line word, arbitrary bit alignment.
- sloop  in  1  1 = RX input is tx_word instead of rx_word.
- dout  out  33  recovered payload.
- dout_fix  out  1  single-bit error corrected in this word.
- dout_fail  out  1  uncorrectable error in this word.
- rx_wordlock  out  1  word alignment locked.
- rx_offset  out  6  current alignment offset, 0..39 (debug).

Behaviour:
- Reset values: all outputs 0. Scrambler and descrambler state = SCRAM_INIT. Offset 0. FSM in HUNT. Counters 0.
- Scramble function: f(x) = {x[25:0],x[32:26]} ^ {x[13:0],x[32:14]}.
- TX scrambling: s = din ^ f(s_prev). s_prev <= s every cycle.
- SECDED encode: Hamming positions 1..39.
  - Check bits sit at positions 1,2,4,8,16,32.
  - s[0..32] fill the remaining positions in ascending order.
  - Check bit at position 2^k = XOR of all positions with bit k set.
  - Bit 0 = XOR of bits 1..39 (even overall parity).
  - tx_word[i] = position i. Registered: 1 cycle latency from din.
- RX input selection: in = sloop ? tx_word : rx_word, registered into r1. r2 <= r1.
- Alignment: aligned = {r1,r2}[offset +: 40].
- Decode (combinational on aligned):
  - syn = XOR of indices of set bits in positions 1..39; p = XOR of all 40 bits.
  - syn==0, p==0: clean.
  - p==1, syn<=39: flip bit syn (syn 0 means the parity bit), fix=1.
  - p==1, syn>39: fail=1.
  - p==0, syn!=0: fail=1, data passed through uncorrected.
- Descramble: d = s_rx ^ f(q), where s_rx is the extracted (corrected) data bits. q <= s_rx on every word, including failed words. The path is self-synchronising after one clean word.
- Output register: dout, dout_fix, dout_fail registered from decode/descramble. rx_word to dout latency = 3 cycles. din to dout in loopback = 4 cycles.
- Lock FSM, evaluated every cycle on the combinational fail:
  - HUNT, word not failed: good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED and set rx_wordlock=1 on the next edge.
  - HUNT, word failed: good_cnt=0 and offset slips by one (offset = offset==39 ? 0 : offset+1; 39 wraps to 0).
  - LOCKED, word failed: bad_cnt++. When bad_cnt reaches UNLOCK_CNT, go to HUNT, rx_wordlock=0, clear counters. Offset is kept (no slip that cycle).
  - LOCKED, word not failed: bad_cnt=0.
  - fix words count as good.
  - In LOCKED, offset never changes.
- dout is driven whether or not locked. Consumers qualify it with rx_wordlock.
- arst mid-operation: all state returns to reset values immediately; operation resumes on the first edge after release.

Test Plan:
- sloop=1, din increments by 1 per cycle from 0:
  - rx_wordlock rises within LOCK_CNT+2 cycles (offset 0).
  - Afterwards dout[n] == dout[n-1]+1 every cycle, and dout == din delayed 4 cycles.
  - fix=fail=0.
- Locked loopback, flip tx_word bit 17 for one cycle: exactly one dout_fix pulse 3 cycles later. dout sequence stays unbroken. Lock held.
- Locked, flip bits 5 and 30 of one word: one dout_fail pulse. dout wrong for at most 2 words, then resumes +1 sequence. Lock held.
- sloop=0, rx_word = tx stream delayed by 17 bits:
  - HUNT slips until offset 17 (or 17 equivalent).
  - rx_wordlock=1 and the increment check passes afterwards.
- Locked, corrupt 4 consecutive words with double errors:
  - rx_wordlock drops after the 4th.
  - 3 corrupted words only: lock stays.
- Assert arst mid-stream: all outputs 0 immediately and offset 0. Relock follows as in the first scenario.
